// File: rtl/inst_mem_loader.sv
// inst_mem_loader: write-side engine for the blocking instruction memory.
// Pops words from the upstream FIFO, writes them tagged valid at consecutive
// addresses, releases PCstart once enough code is preloaded and raises halt
// once the reader has caught up and the FIFO stays drained.
module inst_mem_loader #(
    parameter int          NUM_WORD = 16,
    parameter int          PRELOAD  = 4,
    parameter int          HALT_CYC = 8,
    parameter logic [31:0] NOOP     = 32'hFC00003F,
    localparam int         CW       = $clog2(NUM_WORD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic [31:0]   fifo_data,
    output logic          fifo_rd_en,
    output logic [31:0]   WRaddr,
    output logic [32:0]   WRdata,
    output logic          EMPTY,
    input  logic          STOP,
    output logic          PCstart,
    output logic [CW-1:0] wr_count,
    output logic          full,
    output logic          halt
);

    localparam int IW = $clog2(PRELOAD + 1);
    localparam int HW = $clog2(HALT_CYC + 1);

    localparam logic [CW-1:0] LAST_M1   = CW'(NUM_WORD - 1);
    localparam logic [CW-1:0] PRE_M1    = CW'(PRELOAD - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(PRELOAD - 1);
    localparam logic [HW-1:0] HALT_LAST = HW'(HALT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        FULL  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_addr;
    logic [32:0]     r_data;
    logic            r_empty;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_pcstart;
    logic            r_halt;
    logic [IW-1:0]   r_idle_cnt;
    logic [HW-1:0]   r_halt_cnt;

    logic            w_idle_cond;
    logic            w_halt_cond;
    logic            w_pre_hit;
    logic            w_short_hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; fifo_rd_en is a pure Moore output of POP
    always_comb begin
        w_next     = r_state;
        fifo_rd_en = 1'b0;
        case (r_state)
            IDLE:  if (!fifo_empty && !r_full) w_next = POP;
            POP: begin
                fifo_rd_en = 1'b1;
                w_next     = CAPT;
            end
            CAPT:  w_next = WRITE;
            WRITE: begin
                if (r_count == LAST_M1) w_next = FULL;
                else if (!fifo_empty)   w_next = POP;
                else                    w_next = IDLE;
            end
            FULL:  w_next = FULL;
            default: w_next = IDLE;
        endcase
    end

    // Write port: capture the popped word, hold it through WRITE, then commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_data  <= {1'b0, NOOP};
            r_empty <= 1'b1;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            case (r_state)
                CAPT: begin
                    r_data  <= {1'b1, fifo_data};
                    r_empty <= 1'b0;
                end
                WRITE: begin
                    // valid tag drops with EMPTY so {1,1} never reaches memory
                    r_empty    <= 1'b1;
                    r_data[32] <= 1'b0;
                    r_count    <= r_count + 1'b1;
                    if (r_count == LAST_M1) r_full <= 1'b1;
                    else                    r_addr <= r_addr + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign w_idle_cond = (r_state == IDLE) && fifo_empty && (r_count != '0);
    assign w_short_hit = w_idle_cond && (r_idle_cnt == IDLE_LAST);
    assign w_pre_hit   = (r_state == WRITE) && (r_count == PRE_M1);

    // Short-program timer: consecutive idle/empty cycles with code loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_idle_cnt <= '0;
        else if (!w_idle_cond)            r_idle_cnt <= '0;
        else if (r_idle_cnt != IDLE_LAST) r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    // PCstart is sticky: set on preload threshold or short-program timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_pcstart <= 1'b0;
        else if (w_pre_hit || w_short_hit) r_pcstart <= 1'b1;
    end

    assign w_halt_cond = STOP && fifo_empty && r_pcstart &&
                         ((r_state == IDLE) || (r_state == FULL));

    // Halt timer: any break in the drained condition restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_halt_cnt <= '0;
        else if (!w_halt_cond)            r_halt_cnt <= '0;
        else if (r_halt_cnt != HALT_LAST) r_halt_cnt <= r_halt_cnt + 1'b1;
    end

    // Sticky halt flag, set on the HALT_CYC-th qualifying cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_halt <= 1'b0;
        else if (w_halt_cond && r_halt_cnt == HALT_LAST) r_halt <= 1'b1;
    end

    assign WRaddr   = r_addr;
    assign WRdata   = r_data;
    assign EMPTY    = r_empty;
    assign wr_count = r_count;
    assign full     = r_full;
    assign PCstart  = r_pcstart;
    assign halt     = r_halt;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: FIFO model, scoreboard of expected memory
// writes checked by a monitor, plus directed timing checks.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_rd_en;
    logic [31:0] WRaddr;
    logic [32:0] WRdata;
    logic        EMPTY;
    logic        STOP = 1'b0;
    logic        PCstart;
    logic [4:0]  wr_count;
    logic        full;
    logic        halt;

    inst_mem_loader dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .WRaddr(WRaddr), .WRdata(WRdata), .EMPTY(EMPTY),
        .STOP(STOP), .PCstart(PCstart), .wr_count(wr_count), .full(full), .halt(halt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int pops = 0;
    int cyc = 0;
    int last_pop = -100;
    int exp_addr = 0;
    logic [31:0] fq[$];
    logic [31:0] exp_a[$];
    logic [32:0] exp_d[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus side: word enters the FIFO, expected write enters the scoreboard
    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
        if (exp_addr < 16) begin
            exp_a.push_back(exp_addr);
            exp_d.push_back({1'b1, w});
            exp_addr++;
        end
    endtask

    task automatic drained(input string name);
        chk(name, exp_a.size(), 0);
    endtask

    // Asserts reset immediately, checks reset values, releases after two edges
    task automatic do_reset();
        rst = 1'b1;
        STOP = 1'b0;
        fq.delete();
        exp_a.delete();
        exp_d.delete();
        exp_addr = 0;
        fifo_empty = 1'b1;
        pops = 0;
        last_pop = -100;
        #1;
        chk("rst_WRaddr", WRaddr, 0);
        chk("rst_WRdata", WRdata, {1'b0, 32'hFC00003F});
        chk("rst_EMPTY", EMPTY, 1);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_full", full, 0);
        chk("rst_PCstart", PCstart, 0);
        chk("rst_halt", halt, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // FIFO model: data appears the cycle after the pop request
    always @(negedge clk) begin
        cyc++;
        if (!rst && fifo_rd_en) begin
            chk("pop_gap", (cyc - last_pop) >= 3, 1);
            last_pop = cyc;
            pops++;
            if (fq.size() > 0) fifo_data = fq.pop_front();
            else chk("fifo_underflow", 1, 0);
        end
        fifo_empty = (fq.size() == 0);
    end

    // Monitor: invariant every cycle, scoreboard pop on each presented write
    always @(negedge clk) begin
        if (!rst) begin
            chk("tag_invariant", EMPTY ^ WRdata[32], 1);
            if (!EMPTY) begin
                if (exp_a.size() == 0) chk("unexpected_write", WRaddr, 32'hFFFFFFFF);
                else begin
                    chk("wr_addr", WRaddr, exp_a.pop_front());
                    chk("wr_data", WRdata, exp_d.pop_front());
                end
            end
        end
    end

    initial begin
        bit seen3, seen4;
        @(negedge clk);
        #1 do_reset();

        // 1: reset during the second WRITE abandons it, reload restarts at 0
        push(32'h11111111); push(32'h22222222); push(32'h33333333);
        for (int i = 0; i < 50 && !(wr_count == 1 && !EMPTY); i++) @(negedge clk);
        chk("t1_reach_write2", (wr_count == 1 && !EMPTY), 1);
        #2 do_reset();
        push(32'hA5A5A5A5);
        for (int i = 0; i < 50 && wr_count != 1; i++) @(negedge clk);
        chk("t1_reload_count", wr_count, 1);
        chk("t1_reload_addr", WRaddr, 1);
        drained("t1_sb");

        // 2: six words back-to-back, PCstart at the fourth commit
        do_reset();
        for (int k = 0; k < 6; k++) push(32'h1000_0000 + k);
        seen3 = 0; seen4 = 0;
        for (int i = 0; i < 100 && wr_count != 6; i++) begin
            if (wr_count == 3 && !seen3) begin seen3 = 1; chk("t2_pc_before", PCstart, 0); end
            if (wr_count == 4 && !seen4) begin seen4 = 1; chk("t2_pc_at4", PCstart, 1); end
            @(negedge clk);
        end
        chk("t2_count", wr_count, 6);
        chk("t2_pops", pops, 6);
        chk("t2_addr", WRaddr, 6);
        drained("t2_sb");

        // 3: short program, PCstart after 4 idle cycles with 2 words
        do_reset();
        push(32'hDEAD0001); push(32'hDEAD0002);
        for (int i = 0; i < 50 && wr_count != 2; i++) @(negedge clk);
        chk("t3_count", wr_count, 2);
        chk("t3_pc_at0", PCstart, 0);
        repeat (3) @(negedge clk);
        chk("t3_pc_at3", PCstart, 0);
        @(negedge clk);
        chk("t3_pc_at4", PCstart, 1);
        repeat (5) @(negedge clk);
        chk("t3_pops", pops, 2);
        drained("t3_sb");

        // 4: more words than memory, stops at 16
        do_reset();
        for (int k = 0; k < 20; k++) push(32'hC000_0000 + k);
        for (int i = 0; i < 200 && !full; i++) @(negedge clk);
        chk("t4_full", full, 1);
        chk("t4_addr", WRaddr, 15);
        chk("t4_count", wr_count, 16);
        chk("t4_pops", pops, 16);
        repeat (10) @(negedge clk);
        chk("t4_pops_after", pops, 16);
        chk("t4_rd_en", fifo_rd_en, 0);
        chk("t4_fifo_nonempty", fifo_empty, 0);
        drained("t4_sb");

        // 5a: drained program with STOP high halts after 8 cycles
        do_reset();
        STOP = 1'b1;
        push(32'h0BAD0001); push(32'h0BAD0002);
        for (int i = 0; i < 50 && !PCstart; i++) @(negedge clk);
        chk("t5_pcstart", PCstart, 1);
        repeat (7) @(negedge clk);
        chk("t5_halt_at7", halt, 0);
        @(negedge clk);
        chk("t5_halt_at8", halt, 1);
        drained("t5_sb");

        // 5b: a new word at cycle 5 clears the count, halt restarts from 0
        do_reset();
        STOP = 1'b1;
        push(32'h0BAD0003); push(32'h0BAD0004);
        for (int i = 0; i < 50 && !PCstart; i++) @(negedge clk);
        chk("t5b_pcstart", PCstart, 1);
        repeat (4) @(negedge clk);
        #1 push(32'h0BAD0005);
        for (int i = 0; i < 50 && wr_count != 3; i++) @(negedge clk);
        chk("t5b_count", wr_count, 3);
        chk("t5b_halt_resume", halt, 0);
        repeat (7) @(negedge clk);
        chk("t5b_halt_at7", halt, 0);
        @(negedge clk);
        chk("t5b_halt_at8", halt, 1);
        chk("t5b_pops", pops, 3);
        drained("t5b_sb");

        // 6: random arrival gaps, invariant checked by the monitor
        do_reset();
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            #1 push(32'h6000_0000 + k * 32'h0101);
        end
        for (int i = 0; i < 300 && wr_count != 10; i++) @(negedge clk);
        chk("t6_count", wr_count, 10);
        repeat (3) @(negedge clk);
        drained("t6_sb");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
